bldc_commutator: RTL

BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

---
 rtl/bldc_commutator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: synchronised and filtered hall decode, complementary PWM on the
// high-side phase, and a per-phase OFF/HIGH/LOW/DEAD sequencer with dead-time insertion.
module bldc_commutator #(
   parameter int unsigned DUTY_WIDTH  = 8,
   parameter int unsigned DEAD_TIME   = 4,
   parameter int unsigned HALL_FILTER = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [2:0]            hall,
   input  logic [DUTY_WIDTH-1:0] duty,
   input  logic                  direction,
   input  logic                  enable,
   input  logic                  brake,
   output logic [2:0]            phase_h,
   output logic [2:0]            phase_l,
   output logic                  hall_fault
);

   typedef enum logic [1:0] {OFF, HIGH, LOW, DEAD} phaseStateT;

   localparam logic [DUTY_WIDTH-1:0] PWM_MAX   = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [7:0]            DEAD_LOAD = 8'(DEAD_TIME - 1);
   localparam logic [3:0]            FILT      = 4'(HALL_FILTER);

   logic [2:0]            hallMeta, hallSync, hallLast, hallCode;
   logic [3:0]            filtCnt, filtNext;
   logic                  codeValid;
   logic [DUTY_WIDTH-1:0] pwmCnt, dutyLatch;
   logic                  pwmOn;
   logic [2:0]            fwdHigh, fwdLow, highMask, lowMask;
   phaseStateT            state [3];
   phaseStateT            target [3];
   logic [7:0]            deadCnt [3];

   // Run length of identical synchronised samples, counting the current one.
   always_comb begin
      filtNext = filtCnt;
      if (hallSync != hallLast)
         filtNext = 4'd1;
      else if (filtCnt < FILT)
         filtNext = filtCnt + 4'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hallMeta   <= '0;
         hallSync   <= '0;
         hallLast   <= '0;
         filtCnt    <= '0;
         hallCode   <= '0;
         codeValid  <= 1'b0;
         hall_fault <= 1'b0;
      end else begin
         hallMeta <= hall;
         hallSync <= hallMeta;
         hallLast <= hallSync;
         filtCnt  <= filtNext;
         if (filtNext >= FILT) begin
            hallCode  <= hallSync;
            codeValid <= 1'b1;
         end
         hall_fault <= codeValid && (hallCode == 3'b000 || hallCode == 3'b111);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pwmCnt    <= '0;
         dutyLatch <= '0;
      end else if (pwmCnt == PWM_MAX) begin
         pwmCnt    <= '0;
         dutyLatch <= duty;
      end else begin
         pwmCnt <= pwmCnt + 1'b1;
      end
   end

   assign pwmOn = pwmCnt < dutyLatch;

   always_comb begin
      fwdHigh = 3'b000;
      fwdLow  = 3'b000;
      case (hallCode)
         3'b101: begin fwdHigh = 3'b100; fwdLow = 3'b010; end
         3'b100: begin fwdHigh = 3'b100; fwdLow = 3'b001; end
         3'b110: begin fwdHigh = 3'b010; fwdLow = 3'b001; end
         3'b010: begin fwdHigh = 3'b010; fwdLow = 3'b100; end
         3'b011: begin fwdHigh = 3'b001; fwdLow = 3'b100; end
         3'b001: begin fwdHigh = 3'b001; fwdLow = 3'b010; end
         default: ;
      endcase
      highMask = direction ? fwdLow  : fwdHigh;
      lowMask  = direction ? fwdHigh : fwdLow;
   end

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         target[i] = OFF;
         if (brake)
            target[i] = LOW;
         else if (!enable || hall_fault)
            target[i] = OFF;
         else if (highMask[i])
            target[i] = pwmOn ? HIGH : LOW;
         else if (lowMask[i])
            target[i] = LOW;
      end
   end

   // Gate outputs are decided together with the next state so they never lag it.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         phase_h <= '0;
         phase_l <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            state[i]   <= OFF;
            deadCnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            phase_h[i] <= 1'b0;
            phase_l[i] <= 1'b0;
            case (state[i])
               OFF: begin
                  if (target[i] != OFF) begin
                     state[i]   <= DEAD;
                     deadCnt[i] <= DEAD_LOAD;
                  end
               end
               HIGH: begin
                  if (target[i] == HIGH) begin
                     phase_h[i] <= 1'b1;
                  end else if (target[i] == OFF) begin
                     state[i] <= OFF;
                  end else begin
                     state[i]   <= DEAD;
                     deadCnt[i] <= DEAD_LOAD;
                  end
               end
               LOW: begin
                  if (target[i] == LOW) begin
                     phase_l[i] <= 1'b1;
                  end else if (target[i] == OFF) begin
                     state[i] <= OFF;
                  end else begin
                     state[i]   <= DEAD;
                     deadCnt[i] <= DEAD_LOAD;
                  end
               end
               default: begin
                  // The dead counter is never restarted; exit goes to whatever the target is now.
                  if (target[i] == OFF) begin
                     state[i] <= OFF;
                  end else if (deadCnt[i] == 8'd0) begin
                     state[i]   <= target[i];
                     phase_h[i] <= (target[i] == HIGH);
                     phase_l[i] <= (target[i] == LOW);
                  end else begin
                     deadCnt[i] <= deadCnt[i] - 8'd1;
                  end
               end
            endcase
         end
      end
   end

endmodule
